// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a. MEM_ARB_FAIRNESS_EN (in mem_arbiter) is the only consumer of FAIR_LIMIT.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;

    // Consecutive data grants tolerated while a fetch waits, before fetch takes a turn.
    localparam logic [1:0] FAIR_LIMIT = 2'd3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-side, data-side and memory-side signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: Ready strobes and Stall levels are produced by the arbiter (slave side).
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // Fetch side
    logic  IReq;
    word_t IAddr;
    logic  FlushF;
    word_t IRData;
    logic  IReady;
    logic  IStall;

    // Data side
    logic  DReq;
    logic  DWE;
    word_t DAddr;
    word_t DWData;
    word_t DRData;
    logic  DReady;
    logic  DStall;

    // Memory side
    logic  MemReq;
    logic  MemWE;
    word_t MemAddr;
    word_t MemWData;
    word_t MemRData;
    logic  MemReady;

    // Arbiter view
    modport slave (
        input  IReq, IAddr, FlushF,
        input  DReq, DWE, DAddr, DWData,
        input  MemRData, MemReady,
        output IRData, IReady, IStall,
        output DRData, DReady, DStall,
        output MemReq, MemWE, MemAddr, MemWData
    );

    // Requesters plus memory view
    modport master (
        output IReq, IAddr, FlushF,
        output DReq, DWE, DAddr, DWData,
        output MemRData, MemReady,
        input  IRData, IReady, IStall,
        input  DRData, DReady, DStall,
        input  MemReq, MemWE, MemAddr, MemWData
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data, data first; MEM_ARB_FAIRNESS_EN gives fetch a turn after 3 data grants.
// Latency: grant at the edge after request, Ready in the MemReady cycle (min 2 cycles); one IDLE cycle between accesses.
// Backpressure: IStall/DStall asserted while a request waits for its Ready; memory operands held until MemReady.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    arb_state_t state;
    logic       drop;
    logic       mem_req;
    logic       mem_we;
    word_t      mem_addr;
    word_t      mem_wdata;
    word_t      irdata_q;
    word_t      drdata_q;

    logic       i_pend;
    logic       i_done;
    logic       d_done;
    logic       i_ready;
    logic       grant_d;
    logic       grant_i;

    // A fetch raised together with FlushF is already cancelled and never competes.
    assign i_pend = bus.IReq & ~bus.FlushF;

    // MemReady only means something while an access is outstanding.
    assign i_done = (state == IBUSY) & bus.MemReady;
    assign d_done = (state == DBUSY) & bus.MemReady;

    // A flush arriving in the completion cycle itself also suppresses the fetch Ready.
    assign i_ready = i_done & ~drop & ~bus.FlushF;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [1:0] fair_cnt;
    logic       fair_turn;

    assign fair_turn = (fair_cnt == FAIR_LIMIT) & i_pend & bus.DReq;
    assign grant_d   = (state == IDLE) & bus.DReq & ~fair_turn;

    // Counts data grants that overtook a waiting fetch; any fetch grant or absent fetch resets it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fair_cnt <= 2'd0;
        end else if (state == IDLE) begin
            if (grant_i || !bus.IReq) begin
                fair_cnt <= 2'd0;
            end else if (grant_d && i_pend && (fair_cnt != FAIR_LIMIT)) begin
                fair_cnt <= fair_cnt + 2'd1;
            end
        end
    end
`else
    assign grant_d = (state == IDLE) & bus.DReq;
`endif

    assign grant_i = (state == IDLE) & i_pend & ~grant_d;

    // Arbitration FSM: latches the winner's operands and drives the memory port from registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            drop      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            irdata_q  <= '0;
            drdata_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (grant_d) begin
                        state     <= DBUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= bus.DWE;
                        mem_addr  <= bus.DAddr;
                        mem_wdata <= bus.DWData;
                    end else if (grant_i) begin
                        state    <= IBUSY;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= bus.IAddr;
                    end
                end
                IBUSY: begin
                    // The memory transaction still runs to completion after a flush.
                    if (bus.FlushF) begin
                        drop <= 1'b1;
                    end
                    if (bus.MemReady) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        drop    <= 1'b0;
                        if (i_ready) begin
                            irdata_q <= bus.MemRData;
                        end
                    end
                end
                DBUSY: begin
                    if (bus.MemReady) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        drdata_q <= bus.MemRData;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    drop    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MemReq   = mem_req;
    assign bus.MemWE    = mem_we;
    assign bus.MemAddr  = mem_addr;
    assign bus.MemWData = mem_wdata;

    // Read data passes straight through in the Ready cycle, otherwise the last completed word.
    assign bus.IReady = i_ready;
    assign bus.IRData = i_ready ? bus.MemRData : irdata_q;
    assign bus.DReady = d_done;
    assign bus.DRData = d_done ? bus.MemRData : drdata_q;

    assign bus.IStall = bus.IReq & ~i_ready;
    assign bus.DStall = bus.DReq & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers push expected read data, a monitor pops on Ready.
// Latency: memory responder answers after a programmable 0..3 extra cycles.
// Backpressure: drivers hold requests until Ready; every wait is bounded.
module tb_mem_arbiter;

    localparam int TIMEOUT = 300;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          start;
        int          done;
    } grant_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_chk;
    int   n_pass;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] iq [$];
    logic [31:0] dq [$];
    grant_t      glog [$];
    bit          auto_mem;
    int          lat_lo;
    int          lat_hi;
    logic [31:0] last_i;
    logic [31:0] last_d;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Fetch: expected word pushed at issue; retracted again if the fetch is flushed.
    task automatic i_op(input logic [31:0] a, input int flush_k);
        logic [31:0] dummy;
        bit          fin;
        bus.IReq  = 1'b1;
        bus.IAddr = a;
        iq.push_back(ref_mem[a[9:2]]);
        fin = 1'b0;
        for (int n = 0; !fin; n++) begin
            if (n == flush_k) begin
                bus.FlushF = 1'b1;
                dummy = iq.pop_back();
                fin = 1'b1;
            end else begin
                @(negedge clk);
                if (bus.IReady) begin
                    fin = 1'b1;
                end else if (n >= TIMEOUT) begin
                    chk("fetch_ready_in_budget", bus.IReady, 1'b1);
                    fin = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.IReq   = 1'b0;
        bus.FlushF = 1'b0;
    endtask

    // Load/store: a store returns the old word and updates the reference memory.
    task automatic d_op(input logic we, input logic [31:0] a, input logic [31:0] wd);
        bit fin;
        bit scr;
        bus.DReq   = 1'b1;
        bus.DWE    = we;
        bus.DAddr  = a;
        bus.DWData = wd;
        dq.push_back(ref_mem[a[9:2]]);
        if (we) ref_mem[a[9:2]] = wd;
        fin = 1'b0;
        scr = 1'b0;
        for (int n = 0; !fin; n++) begin
            @(negedge clk);
            if (bus.DReady) begin
                fin = 1'b1;
            end else if (n >= TIMEOUT) begin
                chk("data_ready_in_budget", bus.DReady, 1'b1);
                fin = 1'b1;
            end else begin
                // Once our access is on the memory port, garble the operands: they must be latched.
                if (!scr && bus.MemReq && bus.MemAddr == a && bus.MemWE == we) begin
                    bus.DAddr  = $urandom;
                    bus.DWData = $urandom;
                    bus.DWE    = ~we;
                    scr = 1'b1;
                end
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        bus.DReq = 1'b0;
        bus.DWE  = 1'b0;
    endtask

    // Memory responder: logs each access, checks port stability, answers after a random delay.
    initial begin
        grant_t g;
        int k;
        logic [7:0] ix;
        forever begin
            @(posedge clk);
            #1;
            if (auto_mem && bus.MemReq) begin
                g.we    = bus.MemWE;
                g.addr  = bus.MemAddr;
                g.wdata = bus.MemWData;
                g.start = cyc;
                g.done  = -1;
                glog.push_back(g);
                k = $urandom_range(lat_hi, lat_lo);
                repeat (k) begin
                    @(posedge clk);
                    #1;
                end
                chk("mem_req_held", bus.MemReq, 1'b1);
                chk("mem_addr_stable", bus.MemAddr, g.addr);
                chk("mem_we_stable", bus.MemWE, g.we);
                if (g.we) chk("mem_wdata_stable", bus.MemWData, g.wdata);
                if (g.addr < 32'h200) chk("fetch_we_low", g.we, 1'b0);
                ix = g.addr[9:2];
                bus.MemRData = mem[ix];
                if (g.we) mem[ix] = g.wdata;
                bus.MemReady = 1'b1;
                glog[glog.size()-1].done = cyc;
                @(posedge clk);
                #1;
                bus.MemReady = 1'b0;
                bus.MemRData = $urandom;
            end
        end
    end

    // Monitor: pops expectations on Ready, otherwise read data must hold; stall levels follow requests.
    initial begin
        last_i = '0;
        last_d = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last_i = '0;
                last_d = '0;
            end else begin
                if (bus.IReady) begin
                    chk("iready_expected", iq.size() > 0, 1'b1);
                    if (iq.size() > 0) begin
                        last_i = iq.pop_front();
                        chk("irdata", bus.IRData, last_i);
                    end
                end else begin
                    chk("irdata_hold", bus.IRData, last_i);
                end
                if (bus.DReady) begin
                    chk("dready_expected", dq.size() > 0, 1'b1);
                    if (dq.size() > 0) begin
                        last_d = dq.pop_front();
                        chk("drdata", bus.DRData, last_d);
                    end
                end else begin
                    chk("drdata_hold", bus.DRData, last_d);
                end
                chk("istall", bus.IStall, bus.IReq & ~bus.IReady);
                chk("dstall", bus.DStall, bus.DReq & ~bus.DReady);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int got;
        int t0;
        cyc      = 0;
        n_chk    = 0;
        n_pass   = 0;
        auto_mem = 1'b1;
        lat_lo   = 0;
        lat_hi   = 0;
        reset_n  = 1'b0;
        bus.IReq = 1'b0; bus.IAddr = '0; bus.FlushF = 1'b0;
        bus.DReq = 1'b0; bus.DWE = 1'b0; bus.DAddr = '0; bus.DWData = '0;
        bus.MemRData = '0; bus.MemReady = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_memreq", bus.MemReq, 1'b0);
        chk("rst_memwe", bus.MemWE, 1'b0);
        chk("rst_memaddr", bus.MemAddr, 32'h0);
        chk("rst_memwdata", bus.MemWData, 32'h0);
        chk("rst_irdata", bus.IRData, 32'h0);
        chk("rst_drdata", bus.DRData, 32'h0);
        chk("rst_iready", bus.IReady, 1'b0);
        chk("rst_dready", bus.DReady, 1'b0);
        #2 reset_n = 1'b1;
        idle(2);

        // Fetch alone, completion in the second busy cycle
        mem[64] = 32'hE3A01005;
        ref_mem[64] = 32'hE3A01005;
        lat_lo = 1; lat_hi = 1;
        glog.delete();
        t0 = cyc;
        i_op(32'h100, -1);
        idle(2);
        chk("fetch_grant_count", glog.size(), 1);
        if (glog.size() == 1) begin
            chk("fetch_memaddr", glog[0].addr, 32'h100);
            chk("fetch_memwe", glog[0].we, 1'b0);
            chk("fetch_grant_cycle", glog[0].start, t0 + 1);
            chk("fetch_busy_len", glog[0].done - glog[0].start, 1);
        end
        chk("fetch_irdata_held", bus.IRData, 32'hE3A01005);

        // Simultaneous requests: store wins, one IDLE cycle, then fetch
        lat_lo = 0; lat_hi = 2;
        glog.delete();
        fork
            d_op(1'b1, 32'h200, 32'hDEADBEEF);
            i_op(32'h104, -1);
        join
        idle(2);
        chk("simul_grant_count", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("simul_first_we", glog[0].we, 1'b1);
            chk("simul_first_addr", glog[0].addr, 32'h200);
            chk("simul_first_wdata", glog[0].wdata, 32'hDEADBEEF);
            chk("simul_second_addr", glog[1].addr, 32'h104);
            chk("simul_idle_gap", glog[1].start - glog[0].done, 2);
        end
        chk("simul_mem_written", mem[128], 32'hDEADBEEF);

        // Fetch raised together with FlushF is not granted
        glog.delete();
        bus.IReq = 1'b1; bus.IAddr = 32'h110; bus.FlushF = 1'b1;
        idle(2);
        chk("flushed_req_no_memreq", bus.MemReq, 1'b0);
        chk("flushed_req_no_grant", glog.size(), 0);
        bus.IReq = 1'b0; bus.FlushF = 1'b0;
        idle(2);

        // Flush during IBUSY: access completes, no IReady
        lat_lo = 3; lat_hi = 3;
        glog.delete();
        i_op(32'h10C, 1);
        idle(6);
        chk("flush_grant_count", glog.size(), 1);
        if (glog.size() == 1) begin
            chk("flush_busy_len", glog[0].done - glog[0].start, 3);
            chk("flush_addr", glog[0].addr, 32'h10C);
        end
        chk("flush_back_idle", bus.MemReq, 1'b0);

        // Random traffic from both requesters
        lat_lo = 0; lat_hi = 3;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    i_op(32'h100 + ($urandom_range(15, 0) << 2),
                         ($urandom_range(4, 0) == 0) ? int'($urandom_range(3, 0)) : -1);
                    idle($urandom_range(2, 0));
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    d_op(1'($urandom_range(1, 0)), 32'h200 + ($urandom_range(7, 0) << 2), $urandom);
                    idle($urandom_range(2, 0));
                end
            end
        join
        idle(8);

        // Both requests held high continuously
        lat_lo = 0; lat_hi = 1;
        glog.delete();
        for (int i = 0; i < 8; i++) begin
            if (FAIR && (i % 4 == 3)) iq.push_back(ref_mem[8'h42]);
            else dq.push_back(ref_mem[8'h82]);
        end
        bus.DReq = 1'b1; bus.DWE = 1'b0; bus.DAddr = 32'h208;
        bus.IReq = 1'b1; bus.IAddr = 32'h108;
        got = 0;
        for (int n = 0; n < TIMEOUT && got < 8; n++) begin
            @(negedge clk);
            if (bus.IReady || bus.DReady) got++;
        end
        chk("contention_completions", got, 8);
        @(posedge clk);
        #1;
        bus.DReq = 1'b0; bus.IReq = 1'b0;
        idle(6);
        chk("contention_grant_count", glog.size(), 8);
        for (int i = 0; i < glog.size() && i < 8; i++)
            chk("contention_grant_is_fetch", glog[i].addr < 32'h200, FAIR && (i % 4 == 3));

        // Reset in the middle of a store
        auto_mem = 1'b0;
        bus.DReq = 1'b1; bus.DWE = 1'b1; bus.DAddr = 32'h210; bus.DWData = $urandom;
        idle(2);
        chk("pre_reset_memreq", bus.MemReq, 1'b1);
        chk("pre_reset_memwe", bus.MemWE, 1'b1);
        #2;
        reset_n = 1'b0;
        bus.MemReady = 1'b1;
        bus.MemRData = $urandom;
        #1;
        chk("arst_memreq", bus.MemReq, 1'b0);
        chk("arst_memwe", bus.MemWE, 1'b0);
        chk("arst_memaddr", bus.MemAddr, 32'h0);
        chk("arst_memwdata", bus.MemWData, 32'h0);
        chk("arst_dready", bus.DReady, 1'b0);
        chk("arst_drdata", bus.DRData, 32'h0);
        chk("arst_irdata", bus.IRData, 32'h0);
        bus.DReq = 1'b0; bus.DWE = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        // MemReady while IDLE must do nothing
        idle(2);
        chk("idle_memready_dready", bus.DReady, 1'b0);
        chk("idle_memready_iready", bus.IReady, 1'b0);
        chk("idle_memready_memreq", bus.MemReq, 1'b0);
        chk("idle_memready_drdata", bus.DRData, 32'h0);
        bus.MemReady = 1'b0;
        auto_mem = 1'b1;
        idle(3);

        chk("fetch_queue_drained", iq.size(), 0);
        chk("data_queue_drained", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these ports (clock and reset first): clk in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-002 Fetch side SHALL be: IReq in 1, fetch request; IAddr in 32, fetch address; FlushF in 1, cancel the current fetch; IRData out 32, fetched word; IReady out 1, fetch complete; IStall out 1, fetch-stage stall request.
REQ-003 Data side SHALL be: DReq in 1, load/store request; DWE in 1, store; DAddr in 32; DWData in 32; DRData out 32; DReady out 1; DStall out 1, memory-stage stall request.
REQ-004 Memory side SHALL be: MemReq out 1; MemWE out 1; MemAddr out 32; MemWData out 32; MemRData in 32; MemReady in 1, one-cycle completion strobe with variable latency.

Function
REQ-005 The block SHALL share one single-port unified memory between fetch and data using a three-state FSM: IDLE, IBUSY, DBUSY.
REQ-006 In IDLE with DReq=1, the FSM SHALL go to DBUSY next cycle and latch DAddr, DWE and DWData into registers.
REQ-007 Otherwise, in IDLE with IReq=1 and FlushF=0, the FSM SHALL go to IBUSY and latch IAddr; IReq with FlushF=1 SHALL NOT be granted.
REQ-008 Arbitration priority SHALL be data over fetch, except as set by REQ-020.
REQ-009 In IBUSY and DBUSY the block SHALL hold MemReq=1 and drive MemAddr, MemWE and MemWData from the latched registers, stable until MemReady; MemWE SHALL be 0 in IBUSY.
REQ-010 In IDLE the block SHALL drive MemReq=0 and MemWE=0.
REQ-011 When MemReady=1 in DBUSY, DReady SHALL be 1 combinationally for that cycle, DRData SHALL equal MemRData, and the FSM SHALL return to IDLE at the next edge.
REQ-012 When MemReady=1 in IBUSY, IReady SHALL be 1 and IRData SHALL equal MemRData, unless the fetch is dropped (REQ-014); the FSM SHALL then return to IDLE.
REQ-013 The minimum access SHALL be 2 cycles (grant edge plus completion cycle); back-to-back accesses SHALL pass through IDLE for exactly one cycle.
REQ-014 FlushF=1 in IBUSY, or in the MemReady cycle, SHALL set a drop flag. The memory transaction SHALL still complete; IReady SHALL stay 0 for it; the flag SHALL clear on return to IDLE.
REQ-015 Stall outputs SHALL be IStall = IReq & ~IReady and DStall = DReq & ~DReady, both combinational.
REQ-016 When IReady or DReady is 0, IRData and DRData SHALL hold their last completed value, held in registers.
REQ-017 MemReady while in IDLE SHALL be ignored.
REQ-018 Requesters SHALL hold Req and operands stable until Ready. Any change to operands mid-access SHALL have no effect because they are latched.

Reset
REQ-019 On reset_n=0, asynchronously: state=IDLE, MemReq=0, MemWE=0, MemAddr=0, MemWData=0, IRData=0, DRData=0, IReady=0, DReady=0, drop flag=0, fairness counter=0. Reset mid-access SHALL abandon the access with no Ready pulse.

Configuration
REQ-020 With MEM_ARB_FAIRNESS_EN defined, a 2-bit counter SHALL count consecutive D grants made while IReq=1 (and FlushF=0). When the count equals 3 and both requests are pending in IDLE, the fetch SHALL be granted. The counter SHALL clear on any I grant or whenever IReq=0 in IDLE.
REQ-021 Without MEM_ARB_FAIRNESS_EN, priority SHALL be strict data-first and no counter SHALL exist.

Structure
REQ-022 A shared package SHALL hold the FSM state enum (IDLE/IBUSY/DBUSY), the 32-bit word width constant and the fairness limit constant (3).
REQ-023 The block SHALL be a single module, with no sub-modules.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Fetch alone: IReq=1, IAddr=0x100, MemReady on the 2nd busy cycle with MemRData=0xE3A01005 -> MemAddr=0x100, IReady pulses once, IRData=0xE3A01005, IStall=1 until then.
- Simultaneous requests: IReq=DReq=1 in IDLE, DWE=1, DAddr=0x200, DWData=0xDEADBEEF -> DBUSY first with MemWE=1; after DReady, one IDLE cycle, then IBUSY.
- Flush: FlushF=1 during IBUSY -> MemReq held until MemReady, IReady stays 0, IRData unchanged, back to IDLE.
- Fairness (macro defined): DReq and IReq held high continuously -> grant order D,D,D,I,D,D,D,I; with the macro undefined, fetch is never granted.
- Reset: reset_n=0 mid-DBUSY -> MemReq=0 and all outputs 0 immediately, DReady never pulses; MemReady in IDLE is ignored.
